// File: rtl/apb4_slave_regfile.sv
// APB4 completer wrapping a byte-strobed register file with programmable wait
// states, read-only words and PSLVERR reporting for misaligned/out-of-range/RO accesses.
module apb4_slave_regfile #(
  parameter int unsigned         ADDR_WIDTH  = 32,
  parameter int unsigned         DATA_WIDTH  = 32,
  parameter int unsigned         NUM_REGS    = 16,
  parameter int unsigned         WAIT_STATES = 0,
  parameter logic [NUM_REGS-1:0] RO_MASK     = '0
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int unsigned NB = DATA_WIDTH / 8;
  localparam int unsigned AL = $clog2(NB);
  localparam int unsigned IW = $clog2(NUM_REGS);
  localparam int unsigned CW = 4;

  // Address bits below the word offset must be zero; bits above the index field must be zero.
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK  = {ADDR_WIDTH{1'b1}} >> (ADDR_WIDTH - AL);
  localparam logic [ADDR_WIDTH-1:0] HIGH_MASK = {ADDR_WIDTH{1'b1}} << (AL + IW);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS
  } state_e;

  state_e                r_state;
  state_e                w_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NB-1:0]         r_strb;
  logic [CW-1:0]         r_cnt;
  logic                  r_pready;
  logic                  r_pslverr;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic [IW-1:0]         w_live_idx;
  logic [IW-1:0]         w_lat_idx;
  logic                  w_live_err;
  logic                  w_lat_err;
  logic [DATA_WIDTH-1:0] w_live_rdata;
  logic [DATA_WIDTH-1:0] w_lat_rdata;

  function automatic logic f_err(input logic [ADDR_WIDTH-1:0] addr, input logic wr);
    logic [IW-1:0] idx;
    idx = addr[AL +: IW];
    return (|(addr & LOW_MASK)) || (|(addr & HIGH_MASK)) || (wr && RO_MASK[idx]);
  endfunction

  // The SETUP phase is recognised from the bus itself so the transfer is latched at the
  // edge closing it; this is what lets PREADY rise in the first ACCESS cycle.
  assign w_state = (r_state == ST_IDLE && PSEL && !PENABLE) ? ST_SETUP : r_state;

  assign w_live_idx   = PADDR[AL +: IW];
  assign w_lat_idx    = r_addr[AL +: IW];
  assign w_live_err   = f_err(PADDR, PWRITE);
  assign w_lat_err    = f_err(r_addr, r_write);
  assign w_live_rdata = (PWRITE || w_live_err) ? '0 : r_regs[w_live_idx];
  assign w_lat_rdata  = (r_write || w_lat_err) ? '0 : r_regs[w_lat_idx];

  // NOTE: all state below uses non-blocking assignments so every register samples
  //       pre-edge values, independent of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_strb    <= '0;
      r_cnt     <= '0;
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;
      // NOTE: the register array is reset deliberately: reads of never-written and
      //       read-only words must return 0, so this cannot be left to a RAM macro.
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      // Outputs are single-cycle pulses; any cycle that does not complete drives zeros.
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= '0;

      case (w_state)
        ST_SETUP: begin
          r_addr  <= PADDR;
          r_write <= PWRITE;
          r_wdata <= PWDATA;
          r_strb  <= PSTRB;
          r_cnt   <= CW'(WAIT_STATES);
          r_state <= ST_ACCESS;
          if (WAIT_STATES == 0) begin
            r_pready  <= 1'b1;
            r_pslverr <= w_live_err;
            r_prdata  <= w_live_rdata;
          end
        end

        ST_ACCESS: begin
          if (!PSEL) begin
            r_state <= ST_IDLE;
          end else if (r_pready) begin
            if (r_write && !r_pslverr) begin
              for (int b = 0; b < NB; b++) begin
                if (r_strb[b]) begin
                  r_regs[w_lat_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
              end
            end
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
              r_pready  <= 1'b1;
              r_pslverr <= w_lat_err;
              r_prdata  <= w_lat_rdata;
            end
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign PRDATA  = r_prdata;
  assign PREADY  = r_pready;
  assign PSLVERR = r_pslverr;

endmodule

// File: tb/tb_apb4_slave_regfile.sv
// Scoreboard bench for apb4_slave_regfile: a zero-wait instance and a 3-wait instance
// with register 1 read-only, sharing one APB bus with separate selects.
module tb_apb4_slave_regfile;

  logic        clk;
  logic        rst_n;
  logic [31:0] paddr;
  logic        psel0;
  logic        psel3;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata0;
  logic [31:0] prdata3;
  logic        pready0;
  logic        pready3;
  logic        pslverr0;
  logic        pslverr3;

  int n_total = 0;
  int n_pass  = 0;
  int cyc     = 0;
  bit mon_en  = 1'b0;

  typedef struct {
    int          dut;
    logic [31:0] rdata;
    logic        err;
    int          start;
    int          lat;
  } exp_t;

  exp_t q[$];

  apb4_slave_regfile #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (16),
    .WAIT_STATES(0),
    .RO_MASK    (16'h0000)
  ) u_dut_ws0 (
    .PCLK   (clk),
    .PRESETn(rst_n),
    .PADDR  (paddr),
    .PSEL   (psel0),
    .PENABLE(penable),
    .PWRITE (pwrite),
    .PWDATA (pwdata),
    .PSTRB  (pstrb),
    .PRDATA (prdata0),
    .PREADY (pready0),
    .PSLVERR(pslverr0)
  );

  apb4_slave_regfile #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .NUM_REGS   (16),
    .WAIT_STATES(3),
    .RO_MASK    (16'h0002)
  ) u_dut_ws3 (
    .PCLK   (clk),
    .PRESETn(rst_n),
    .PADDR  (paddr),
    .PSEL   (psel3),
    .PENABLE(penable),
    .PWRITE (pwrite),
    .PWDATA (pwdata),
    .PSTRB  (pstrb),
    .PRDATA (prdata3),
    .PREADY (pready3),
    .PSLVERR(pslverr3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic mon_one(input int d, input logic rdy, input logic [31:0] rd, input logic err);
    exp_t e;
    if (rdy) begin
      check("queue_nonempty", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("dut_id", 32'(d), 32'(e.dut));
        check("prdata", rd, e.rdata);
        check("pslverr", 32'(err), 32'(e.err));
        check("latency", 32'(cyc - e.start + 1), 32'(e.lat));
      end
    end else begin
      check("idle_prdata", rd, 32'd0);
      check("idle_pslverr", 32'(err), 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon_one(0, pready0, prdata0, pslverr0);
      mon_one(3, pready3, prdata3, pslverr3);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the completing edge, so consecutive
  // calls are back-to-back with no idle cycle in between.
  task automatic xfer(input int dut, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [3:0] strb,
                      input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    bit   got;
    e.dut   = dut;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.start = cyc;
    e.lat   = (dut == 0) ? 2 : 5;
    q.push_back(e);
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wdata;
    pstrb   = strb;
    penable = 1'b0;
    psel0   = (dut == 0);
    psel3   = (dut == 3);
    @(posedge clk);
    #1;
    penable = 1'b1;
    // Scrambled bus during ACCESS: the completer must use the values captured in SETUP.
    paddr   = ~addr;
    pwrite  = ~wr;
    pwdata  = ~wdata;
    pstrb   = ~strb;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if ((dut == 0) ? pready0 : pready3) begin
        got = 1'b1;
        break;
      end
    end
    check("ready_seen", 32'(got), 32'd1);
    if (!got) q.delete();
    @(posedge clk);
    #1;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b1;
    paddr   = '0;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    pwdata  = '0;
    pstrb   = '0;
    #3 rst_n = 1'b0;
    #4;
    check("rst_pready0", 32'(pready0), 32'd0);
    check("rst_pready3", 32'(pready3), 32'd0);
    check("rst_prdata0", prdata0, 32'd0);
    check("rst_pslverr3", 32'(pslverr3), 32'd0);
    idle(2);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(1);

    // Reset contents
    xfer(0, 32'h00, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(3, 32'h3C, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(1);

    // Zero-wait write then read
    xfer(0, 32'h08, 1'b1, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0);
    idle(1);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0);
    idle(1);

    // Byte strobes, including the all-zero strobe no-op
    xfer(0, 32'h04, 1'b1, 32'h11223344, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h04, 1'b1, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0);
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    xfer(0, 32'h04, 1'b1, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0);
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);

    // Errors on the zero-wait instance
    xfer(0, 32'h0A, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, 32'h80000004, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(0, 32'h05, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 32'h11BB33DD, 1'b0);
    idle(1);

    // Wait states and errors on the 3-wait instance
    xfer(3, 32'h00, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(3, 32'h08, 1'b1, 32'h12345678, 4'hF, 32'h0, 1'b0);
    xfer(3, 32'h02, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(3, 32'h40, 1'b0, 32'h0, 4'h0, 32'h0, 1'b1);
    xfer(3, 32'h04, 1'b1, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1);
    xfer(3, 32'h04, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(3, 32'h09, 1'b1, 32'h0, 4'hF, 32'h0, 1'b1);
    xfer(3, 32'h08, 1'b0, 32'h0, 4'h0, 32'h12345678, 1'b0);
    idle(2);

    // Back-to-back write/read with no bubble
    xfer(0, 32'h0C, 1'b1, 32'h0BADF00D, 4'hF, 32'h0, 1'b0);
    xfer(0, 32'h0C, 1'b0, 32'h0, 4'h0, 32'h0BADF00D, 1'b0);
    xfer(3, 32'h0C, 1'b1, 32'h600DCAFE, 4'hF, 32'h0, 1'b0);
    xfer(3, 32'h0C, 1'b0, 32'h0, 4'h0, 32'h600DCAFE, 1'b0);
    idle(1);

    // PSEL dropped during the ACCESS wait: no write, no PREADY
    paddr = 32'h14; pwrite = 1'b1; pwdata = 32'h00000055; pstrb = 4'hF;
    psel3 = 1'b1; penable = 1'b0;
    idle(1);
    penable = 1'b1;
    idle(1);
    psel3 = 1'b0; penable = 1'b0;
    idle(5);
    xfer(3, 32'h14, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(1);

    // Reset during the ACCESS wait of a write to 0x10
    paddr = 32'h10; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF;
    psel3 = 1'b1; penable = 1'b0;
    idle(1);
    penable = 1'b1;
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("abort_pready3", 32'(pready3), 32'd0);
    check("abort_prdata3", prdata3, 32'd0);
    check("abort_pslverr3", 32'(pslverr3), 32'd0);
    psel3 = 1'b0; penable = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    xfer(3, 32'h10, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(3, 32'h08, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(0, 32'h08, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    xfer(0, 32'h04, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0);
    idle(3);

    check("queue_drained", 32'(q.size()), 32'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
